// File: rtl/id_ex_stage.sv
// ============================================================================
// Module   : id_ex_stage
// Purpose  : Decode-to-execute pipeline register with valid/ready handshake,
//            ALU operand select, writeback forwarding/snoop and flush.
//            Optional stall counter enabled by macro ID_EX_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
`ifdef ID_EX_STALL_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [XLEN-1:0] in_imm,
    input  logic [RA_W-1:0] in_rs1,
    input  logic [RA_W-1:0] in_rs2,
    input  logic [RA_W-1:0] in_rd,
    input  logic            in_use_pc,
    input  logic            in_use_imm,
    input  logic [3:0]      in_alu_sel,
    input  logic            in_reg_write,
    input  logic            wb_en,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] tmpA,
    output logic [XLEN-1:0] tmpB,
    output logic [3:0]      ALU_Sel,
    output logic [RA_W-1:0] out_rd,
    output logic            out_reg_write,
    output logic            out_illegal
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_count
`endif
);

    logic            held_valid;
    logic [XLEN-1:0] held_pc, held_rs1_val, held_rs2_val, held_imm;
    logic [RA_W-1:0] held_rs1, held_rs2, held_rd;
    logic            held_use_pc, held_use_imm, held_reg_write;
    logic [3:0]      held_alu_sel;

    logic            next_valid;
    logic [XLEN-1:0] next_pc, next_rs1_val, next_rs2_val, next_imm;
    logic [RA_W-1:0] next_rs1, next_rs2, next_rd;
    logic            next_use_pc, next_use_imm, next_reg_write;
    logic [3:0]      next_alu_sel;

    logic capture, consume, stalled, wb_hit;

    assign in_ready = !held_valid || out_ready;
    assign capture  = in_valid && in_ready && !flush;
    assign consume  = held_valid && out_ready;
    assign stalled  = held_valid && !out_ready && !flush;
    assign wb_hit   = wb_en && (wb_rd != '0);

    always_comb begin
        next_valid     = held_valid;
        next_pc        = held_pc;
        next_rs1_val   = held_rs1_val;
        next_rs2_val   = held_rs2_val;
        next_imm       = held_imm;
        next_rs1       = held_rs1;
        next_rs2       = held_rs2;
        next_rd        = held_rd;
        next_use_pc    = held_use_pc;
        next_use_imm   = held_use_imm;
        next_reg_write = held_reg_write;
        next_alu_sel   = held_alu_sel;

        if (flush) begin
            next_valid = 1'b0;
        end else if (capture) begin
            next_valid     = 1'b1;
            next_pc        = in_pc;
            next_rs1_val   = (wb_hit && wb_rd == in_rs1) ? wb_data : in_rs1_val;
            next_rs2_val   = (wb_hit && wb_rd == in_rs2) ? wb_data : in_rs2_val;
            next_imm       = in_imm;
            next_rs1       = in_rs1;
            next_rs2       = in_rs2;
            next_rd        = in_rd;
            next_use_pc    = in_use_pc;
            next_use_imm   = in_use_imm;
            next_reg_write = in_reg_write;
            next_alu_sel   = in_alu_sel;
        end else if (consume) begin
            next_valid = 1'b0;
        end else if (stalled) begin
            // Keep stalled operands coherent with registers retiring meanwhile.
            if (wb_hit && wb_rd == held_rs1) next_rs1_val = wb_data;
            if (wb_hit && wb_rd == held_rs2) next_rs2_val = wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_valid     <= 1'b0;
            held_pc        <= '0;
            held_rs1_val   <= '0;
            held_rs2_val   <= '0;
            held_imm       <= '0;
            held_rs1       <= '0;
            held_rs2       <= '0;
            held_rd        <= '0;
            held_use_pc    <= 1'b0;
            held_use_imm   <= 1'b0;
            held_reg_write <= 1'b0;
            held_alu_sel   <= '0;
            tmpA           <= '0;
            tmpB           <= '0;
        end else begin
            held_valid     <= next_valid;
            held_pc        <= next_pc;
            held_rs1_val   <= next_rs1_val;
            held_rs2_val   <= next_rs2_val;
            held_imm       <= next_imm;
            held_rs1       <= next_rs1;
            held_rs2       <= next_rs2;
            held_rd        <= next_rd;
            held_use_pc    <= next_use_pc;
            held_use_imm   <= next_use_imm;
            held_reg_write <= next_reg_write;
            held_alu_sel   <= next_alu_sel;
            tmpA           <= next_use_pc  ? next_pc  : next_rs1_val;
            tmpB           <= next_use_imm ? next_imm : next_rs2_val;
        end
    end

    assign out_valid     = held_valid;
    assign ALU_Sel       = held_alu_sel;
    assign out_rd        = held_rd;
    assign out_reg_write = held_reg_write && held_valid;

    always_comb begin
        out_illegal = 1'b0;
        if (held_valid && held_alu_sel[3] && held_alu_sel != 4'b1001 && held_alu_sel != 4'b1010)
            out_illegal = 1'b1;
    end

`ifdef ID_EX_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= '0;
        else if (stalled && stall_count != {CNT_W{1'b1}})
            stall_count <= stall_count + 1'b1;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Directed self-checking bench for id_ex_stage (default build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready;
    logic [31:0] in_pc, in_rs1_val, in_rs2_val, in_imm;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_use_pc, in_use_imm, in_reg_write;
    logic [3:0]  in_alu_sel;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid, out_ready;
    logic [31:0] tmpA, tmpB;
    logic [3:0]  ALU_Sel;
    logic [4:0]  out_rd;
    logic        out_reg_write, out_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_use_pc(in_use_pc), .in_use_imm(in_use_imm),
        .in_alu_sel(in_alu_sel), .in_reg_write(in_reg_write),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .tmpA(tmpA), .tmpB(tmpB), .ALU_Sel(ALU_Sel),
        .out_rd(out_rd), .out_reg_write(out_reg_write), .out_illegal(out_illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] r1v, input logic [31:0] r2v,
                         input logic [31:0] imm, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic upc, input logic uimm,
                         input logic [3:0] sel, input logic rw);
        in_valid = 1'b1; in_pc = pc; in_rs1_val = r1v; in_rs2_val = r2v; in_imm = imm;
        in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_use_pc = upc; in_use_imm = uimm;
        in_alu_sel = sel; in_reg_write = rw;
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        offer(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_valid", out_valid, 0);
        check("rst_tmpA", tmpA, 0);
        check("rst_tmpB", tmpB, 0);
        check("rst_sel", ALU_Sel, 0);
        check("rst_rd", out_rd, 0);
        check("rst_rw", out_reg_write, 0);
        check("rst_illegal", out_illegal, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        step;

        // Single capture, one-cycle latency, then drain
        offer(32'h100, 5, 0, 7, 1, 2, 1, 0, 1, 4'h0, 1);
        step;
        in_valid = 1'b0;
        check("single_valid", out_valid, 1);
        check("single_tmpA", tmpA, 5);
        check("single_tmpB", tmpB, 7);
        check("single_sel", ALU_Sel, 0);
        check("single_rd", out_rd, 1);
        check("single_rw", out_reg_write, 1);
        step;
        check("single_drain_valid", out_valid, 0);
        check("single_drain_rw", out_reg_write, 0);

        // Back-to-back, no bubble
        offer(32'h0, 1, 0, 32'h11, 0, 0, 2, 0, 1, 4'h1, 1);
        step;
        check("b2b1_valid", out_valid, 1);
        check("b2b1_tmpA", tmpA, 1);
        check("b2b1_tmpB", tmpB, 32'h11);
        check("b2b1_ready", in_ready, 1);
        offer(32'h200, 2, 32'h22, 0, 0, 0, 3, 1, 0, 4'h2, 1);
        step;
        check("b2b2_valid", out_valid, 1);
        check("b2b2_tmpA", tmpA, 32'h200);
        check("b2b2_tmpB", tmpB, 32'h22);
        check("b2b2_sel", ALU_Sel, 2);
        check("b2b2_ready", in_ready, 1);
        offer(32'h0, 3, 0, 32'h33, 0, 0, 4, 0, 1, 4'h3, 1);
        step;
        in_valid = 1'b0;
        check("b2b3_valid", out_valid, 1);
        check("b2b3_tmpA", tmpA, 3);
        check("b2b3_tmpB", tmpB, 32'h33);
        check("b2b3_rd", out_rd, 4);
        step;
        check("b2b_end_valid", out_valid, 0);

        // Stall with held snoop on rs2
        out_ready = 1'b0;
        offer(32'h0, 9, 32'h10, 32'hEE, 2, 3, 6, 0, 0, 4'h1, 1);
        step;
        in_valid = 1'b0;
        check("stall1_tmpB", tmpB, 32'h10);
        check("stall1_ready", in_ready, 0);
        step;
        check("stall2_tmpB", tmpB, 32'h10);
        wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'hAB;
        step;
        wb_en = 1'b0;
        check("stall3_tmpB", tmpB, 32'hAB);
        check("stall3_tmpA", tmpA, 9);
        check("stall3_valid", out_valid, 1);
        check("stall3_ready", in_ready, 0);

        // Flush during stall with an instruction offered
        flush = 1'b1;
        offer(32'h300, 32'h77, 0, 0, 0, 0, 5, 0, 0, 4'h2, 1);
        step;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", out_valid, 0);
        check("flush_rw", out_reg_write, 0);
        check("flush_ready", in_ready, 1);
        step;
        check("flush_no_capture", out_valid, 0);

        // Flush while empty and accepting: offer still dropped
        out_ready = 1'b1;
        flush = 1'b1;
        offer(32'h400, 32'h78, 0, 0, 0, 0, 5, 0, 0, 4'h2, 1);
        step;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_empty_valid", out_valid, 0);

        // Capture forwarding: x0 never forwarded
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hFF;
        offer(32'h0, 32'h12, 32'h21, 0, 0, 0, 1, 0, 0, 4'h0, 1);
        step;
        check("fwd_x0_tmpA", tmpA, 32'h12);
        check("fwd_x0_tmpB", tmpB, 32'h21);
        wb_rd = 5'd4; wb_data = 32'h55;
        offer(32'h0, 32'h13, 32'h31, 0, 4, 4, 1, 0, 0, 4'h0, 1);
        step;
        wb_en = 1'b0;
        check("fwd_rs1_tmpA", tmpA, 32'h55);
        check("fwd_rs2_tmpB", tmpB, 32'h55);

        // Illegal code decode
        offer(32'h0, 1, 1, 1, 0, 0, 1, 0, 0, 4'b1000, 0);
        step;
        check("illegal_1000", out_illegal, 1);
        check("illegal_1000_sel", ALU_Sel, 8);
        check("illegal_rw0", out_reg_write, 0);
        offer(32'h0, 1, 1, 1, 0, 0, 1, 0, 0, 4'b1111, 0);
        step;
        check("illegal_1111", out_illegal, 1);
        offer(32'h0, 1, 1, 1, 0, 0, 1, 0, 0, 4'b1010, 0);
        step;
        check("legal_1010", out_illegal, 0);
        offer(32'h0, 1, 1, 1, 0, 0, 1, 0, 0, 4'b1001, 0);
        step;
        check("legal_1001", out_illegal, 0);
        offer(32'h0, 1, 1, 1, 0, 0, 1, 0, 0, 4'b0111, 0);
        step;
        check("legal_0111", out_illegal, 0);
        offer(32'h0, 1, 1, 1, 0, 0, 1, 0, 0, 4'b1111, 0);
        step;
        in_valid = 1'b0;
        step;
        check("illegal_gated_by_valid", out_illegal, 0);

        // Asynchronous reset mid-stall
        out_ready = 1'b0;
        offer(32'h0, 32'h44, 32'h45, 0, 0, 0, 7, 0, 0, 4'b1111, 1);
        step;
        in_valid = 1'b0;
        check("prerst_valid", out_valid, 1);
        check("prerst_illegal", out_illegal, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_tmpA", tmpA, 0);
        check("arst_tmpB", tmpB, 0);
        check("arst_sel", ALU_Sel, 0);
        check("arst_rd", out_rd, 0);
        check("arst_rw", out_reg_write, 0);
        check("arst_illegal", out_illegal, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register sitting directly upstream of the ALU.
- Captures a decoded instruction with a valid/ready handshake and selects ALU operands (PC or rs1 for A; immediate or rs2 for B).
- Presents tmpA, tmpB and ALU_Sel as registered outputs.
- Snoops the writeback bus so operands stay correct at capture and while the entry is stalled.
- Supports pipeline flush.

Parameters:
- XLEN, 32, datapath width
- RA_W, 5, register address width
- CNT_W, 16, stall counter width (optional feature only)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of held and incoming entry
- in_valid  in  1  decode has an instruction
- in_ready  out  1  stage can accept this cycle
- in_pc  in  XLEN  instruction PC
- in_rs1_val  in  XLEN  register-file rs1 data
- in_rs2_val  in  XLEN  register-file rs2 data
- in_imm  in  XLEN  sign-extended immediate
- in_rs1  in  RA_W  rs1 index
- in_rs2  in  RA_W  rs2 index
- in_rd  in  RA_W  destination index
- in_use_pc  in  1  operand A = PC
- in_use_imm  in  1  operand B = immediate
- in_alu_sel  in  4  ALU operation code
- in_reg_write  in  1  instruction writes rd
- wb_en  in  1  writeback valid
- wb_rd  in  RA_W  writeback destination
- wb_data  in  XLEN  writeback value
- out_valid  out  1  held entry valid
- out_ready  in  1  execute consumes entry
- tmpA  out  XLEN  ALU operand A
- tmpB  out  XLEN  ALU operand B
- ALU_Sel  out  4  ALU operation code
- out_rd  out  RA_W  destination index
- out_reg_write  out  1  write enable, gated by out_valid
- out_illegal  out  1  held ALU_Sel is not a defined code
- stall_count  out  CNT_W  stall counter (optional feature only)

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, tmpA=0, tmpB=0, ALU_Sel=0, out_rd=0, out_reg_write=0, out_illegal=0, all internal held state=0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Capture when in_valid && in_ready; out_valid=1 on the next edge. Latency is 1 cycle.
  - Consume when out_valid && out_ready.
  - Consume with no capture: out_valid=0 next cycle.
  - Consume and capture in the same cycle: new entry replaces old, out_valid stays 1 (back-to-back, no bubble).
- Stall: out_valid && !out_ready holds all outputs stable, except for the snoop update below.
- Flush, highest priority:
  - Next edge: out_valid=0 and out_reg_write=0.
  - in_ready still follows its formula, but any input offered that cycle is dropped.
  - Data registers may hold stale values.
- Capture forwarding:
  - If wb_en && wb_rd!=0 && wb_rd==in_rs1, captured rs1 value = wb_data, else in_rs1_val. rs2 is handled the same way.
  - Forwarding applies to x0 never.
- Held snoop:
  - While out_valid && !out_ready && !flush, if wb_en && wb_rd!=0 && wb_rd==held rs1, held rs1 value <= wb_data. rs2 likewise.
  - tmpA/tmpB recompute from held raw values, so only a non-PC A and a non-imm B change.
- Operand select: tmpA = use_pc ? pc : rs1 value; tmpB = use_imm ? imm : rs2 value. Selection uses held flags; outputs are driven from registers (no combinational path from in_* to tmpA/tmpB).
- ALU_Sel passes through unchanged.
- out_illegal = out_valid && ALU_Sel not in {0000..0111, 1001, 1010}.
- out_reg_write = held reg_write && out_valid. If out_rd==0, out_reg_write is still driven as captured; the consumer ignores x0.
- Simultaneous capture and held snoop: capture path wins; forwarding is evaluated on in_rs1/in_rs2.
- Reset mid-stall: entry discarded, outputs return to reset values immediately.

Optional Feature:
- Macro: ID_EX_STALL_CNT_EN.
- Defined:
  - stall_count increments each cycle where out_valid && !out_ready && !flush.
  - Saturates at all-ones.
  - Reset to 0 by rst_n only.
- Undefined: stall_count port absent, no counter logic.

Test Plan:
- Reset then single capture: in_pc=0x100, rs1_val=5, imm=7, use_imm=1, alu_sel=0000, out_ready=1 -> next cycle out_valid=1, tmpA=5, tmpB=7, ALU_Sel=0000; following cycle out_valid=0.
- Back-to-back: three instructions on consecutive cycles with out_ready=1 -> out_valid stays 1 for three cycles, operands in order, in_ready=1 throughout.
- Stall + snoop: entry rs2=3, rs2_val=0x10, out_ready=0 for 3 cycles, wb_en=1 wb_rd=3 wb_data=0xAB in cycle 2 -> tmpB=0xAB from cycle 3; in_ready=0 while stalled; stall_count=3 when enabled.
- Capture forwarding and x0: in_rs1=0, wb_rd=0, wb_data=0xFF -> tmpA=in_rs1_val. in_rs1=4, wb_rd=4, wb_data=0x55 -> tmpA=0x55.
- Flush during stall with in_valid=1 -> next cycle out_valid=0, out_reg_write=0, offered instruction not captured.
- Illegal code ALU_Sel=1000 and 1111 -> out_illegal=1. Code 1010 -> out_illegal=0. Async rst_n pulse mid-stall -> all outputs 0 before the next edge.
